// File: rtl/caliptra_prim_lc_seq_ctrl.sv
// caliptra_prim_lc_seq_ctrl: staged life-cycle enable sequencer.
// One lc_tx_t request is fanned out to NumStages lc_tx_t enables. On power-up
// the stages turn On in ascending order. Each stage waits for its own ack plus
// GapCycles idle cycles before the next stage turns On. On power-down the
// stages turn Off in descending order, one per cycle. An invalid request
// encoding forces every stage Off and sets a sticky error that only reset clears.
// Optional macro CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN adds an ack timeout. When the
// timeout expires, the block enters the error state.
module caliptra_prim_lc_seq_ctrl #(
  parameter int NumStages     = 3,
  parameter int GapCycles     = 2,
  parameter int TimeoutCycles = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [3:0]               lc_en_i,
  input  logic [NumStages*4-1:0]   lc_ack_i,
  output logic [NumStages*4-1:0]   lc_en_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int IdxW = $clog2(NumStages);

  localparam logic [3:0] LcOn  = 4'b0101;
  localparam logic [3:0] LcOff = 4'b1010;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitAck  = 3'd1;
  localparam logic [2:0] StGap      = 3'd2;
  localparam logic [2:0] StActive   = 3'd3;
  localparam logic [2:0] StTeardown = 3'd4;
  localparam logic [2:0] StError    = 3'd5;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumStages - 1);
  localparam logic [7:0]      GapLoad = 8'(GapCycles);

  // Reject out-of-range configurations at elaboration time.
  if (NumStages < 2 || NumStages > 8) begin : g_bad_num_stages
    $error("NumStages must be in 2..8");
  end
  if (GapCycles < 0 || GapCycles > 255) begin : g_bad_gap_cycles
    $error("GapCycles must be in 0..255");
  end
  if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout_cycles
    $error("TimeoutCycles must be in 1..255");
  end

  logic [2:0]           state_reg, state_next;
  logic [IdxW-1:0]      idx_reg, idx_next, idx_plus;
  logic [7:0]           gap_cnt_reg, gap_cnt_next;
  logic [NumStages*4-1:0] lc_en_reg;
  logic [NumStages-1:0] stage_on, stage_next, ack_on;
  logic                 busy_reg, done_reg, err_reg;
  logic                 en_on, en_off, en_bad, step_down;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLoad = 8'(TimeoutCycles);
  logic [7:0]           to_cnt_reg, to_cnt_next;
  logic                 timeout_hit;
`endif

  // Decode every multibit input as a full 4-bit compare.
  assign en_on    = (lc_en_i == LcOn);
  assign en_off   = (lc_en_i == LcOff);
  assign en_bad   = !en_on && !en_off;
  assign idx_plus = idx_reg + IdxW'(1);

  // The request Off signal starts the descending shutdown from any ramping or active state.
  assign step_down = (state_reg == StTeardown) ||
                     (en_off && ((state_reg == StWaitAck) || (state_reg == StGap) ||
                                 (state_reg == StActive)));

`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
  assign timeout_hit = (state_reg == StWaitAck) && (to_cnt_reg == 8'd1);
`endif

  for (genvar gi = 0; gi < NumStages; gi++) begin : g_stage
    assign stage_on[gi] = (lc_en_reg[gi*4 +: 4] == LcOn);
    assign ack_on[gi]   = (lc_ack_i[gi*4 +: 4] == LcOn);

    // Each stage register holds only the On or Off encoding.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lc_en_reg[gi*4 +: 4] <= LcOff;
      end else begin
        lc_en_reg[gi*4 +: 4] <= stage_next[gi] ? LcOn : LcOff;
      end
    end
  end

  // Next-state logic. Priority is: invalid request, timeout, request Off, then ack or gap progress.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    gap_cnt_next = gap_cnt_reg;
    stage_next   = stage_on;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
    to_cnt_next  = 8'd0;
`endif
    if (state_reg == StError) begin
      stage_next = '0;
    end else if (en_bad) begin
      stage_next = '0;
      state_next = StError;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
    end else if (timeout_hit) begin
      stage_next = '0;
      state_next = StError;
`endif
    end else if (step_down) begin
      // Drop the highest asserted stage. Return to Idle once stage 0 is dropped.
      stage_next[idx_reg] = 1'b0;
      gap_cnt_next        = 8'd0;
      if (idx_reg == '0) begin
        state_next = StIdle;
      end else begin
        idx_next   = idx_reg - IdxW'(1);
        state_next = StTeardown;
      end
    end else begin
      case (state_reg)
        StIdle: begin
          if (en_on) begin
            stage_next[0] = 1'b1;
            idx_next      = '0;
            state_next    = StWaitAck;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
            to_cnt_next   = TimeoutLoad;
`endif
          end
        end
        StWaitAck: begin
          if (ack_on[idx_reg]) begin
            if (idx_reg == LastIdx) begin
              state_next = StActive;
            end else if (GapLoad == 8'd0) begin
              stage_next[idx_plus] = 1'b1;
              idx_next             = idx_plus;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
              to_cnt_next          = TimeoutLoad;
`endif
            end else begin
              gap_cnt_next = GapLoad;
              state_next   = StGap;
            end
          end else begin
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
            to_cnt_next = to_cnt_reg - 8'd1;
`endif
          end
        end
        StGap: begin
          if (gap_cnt_reg == 8'd1) begin
            stage_next[idx_plus] = 1'b1;
            idx_next             = idx_plus;
            gap_cnt_next         = 8'd0;
            state_next           = StWaitAck;
`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
            to_cnt_next          = TimeoutLoad;
`endif
          end else begin
            gap_cnt_next = gap_cnt_reg - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, and flop-driven status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= StIdle;
      idx_reg     <= '0;
      gap_cnt_reg <= 8'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      gap_cnt_reg <= gap_cnt_next;
      busy_reg    <= (state_next == StWaitAck) || (state_next == StGap) ||
                     (state_next == StTeardown);
      done_reg    <= (state_next == StActive);
      err_reg     <= (state_next == StError);
    end
  end

`ifdef CALIPTRA_PRIM_LC_SEQ_TIMEOUT_EN
  // Ack timeout counter. It is reloaded whenever a new stage starts waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_reg <= 8'd0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`endif

  assign lc_en_o = lc_en_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign err_o   = err_reg;

endmodule

// File: tb/tb_caliptra_prim_lc_seq_ctrl.sv
// Directed scoreboard bench for caliptra_prim_lc_seq_ctrl (NumStages=3, GapCycles=2).
// Stimulus pushes the expected outputs for the next cycle into a queue.
// A negedge monitor pops each entry and compares it against the DUT outputs.
module tb_caliptra_prim_lc_seq_ctrl;

  localparam logic [3:0]  ON  = 4'b0101;
  localparam logic [3:0]  OFF = 4'b1010;
  localparam logic [11:0] A0  = 12'hAAA;   // no stage acked
  localparam logic [11:0] A1  = 12'hAA5;   // stage 0 acked
  localparam logic [11:0] A2  = 12'hA55;   // stages 0,1 acked
  localparam logic [11:0] A3  = 12'h555;   // all acked
  localparam logic [11:0] ABAD = 12'hAA7;  // stage 0 ack = 4'b0111 (invalid)

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  lc_en_i;
  logic [11:0] lc_ack_i;
  logic [11:0] lc_en_o;
  logic        busy_o, done_o, err_o;

  typedef struct {
    int          cyc;
    int          row;
    logic [11:0] en;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   row_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  caliptra_prim_lc_seq_ctrl #(
    .NumStages(3),
    .GapCycles(2),
    .TimeoutCycles(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .lc_en_i(lc_en_i),
    .lc_ack_i(lc_ack_i),
    .lc_en_o(lc_en_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [11:0] en_vec(input int n_on);
    logic [11:0] v;
    v = 12'hAAA;
    for (int k = 0; k < 3; k++) begin
      if (k < n_on) v[k*4 +: 4] = ON;
    end
    return v;
  endfunction

  // Apply one input vector across one clock edge and queue the expected outputs.
  task automatic vec(input logic r, input logic [3:0] en, input logic [11:0] ack,
                     input int n_on, input logic b, input logic d, input logic e);
    exp_t x;
    rst_i    = r;
    lc_en_i  = en;
    lc_ack_i = ack;
    @(posedge clk);
    #1;
    x.cyc  = cyc_cnt;
    x.row  = row_cnt;
    x.en   = en_vec(n_on);
    x.busy = b;
    x.done = d;
    x.err  = e;
    sb_q.push_back(x);
    row_cnt++;
  endtask

  // Monitor: compare every expectation that is due this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc_cnt) begin
        failures++;
        $display("FAIL row%0d stale_expectation got_cyc=%0d exp_cyc=%0d", mon_e.row, cyc_cnt, mon_e.cyc);
      end else if (lc_en_o !== mon_e.en || busy_o !== mon_e.busy ||
                   done_o !== mon_e.done || err_o !== mon_e.err) begin
        failures++;
        $display("FAIL row%0d outputs got en=%h busy=%b done=%b err=%b exp en=%h busy=%b done=%b err=%b",
                 mon_e.row, lc_en_o, busy_o, done_o, err_o,
                 mon_e.en, mon_e.busy, mon_e.done, mon_e.err);
      end else begin
        $display("row%0d cyc=%0d en=%h busy=%b done=%b err=%b ok",
                 mon_e.row, cyc_cnt, lc_en_o, busy_o, done_o, err_o);
      end
    end
  end

  initial begin
    rst_i = 1'b1; lc_en_i = OFF; lc_ack_i = A0;
    // Reset state
    vec(1, OFF, A0,   0, 0, 0, 0);
    // Power-up: stages at cycles 1,5,9, done at 11
    vec(0, ON,  A0,   1, 1, 0, 0);
    vec(0, ON,  A0,   1, 1, 0, 0);
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   2, 1, 0, 0);
    vec(0, ON,  A1,   2, 1, 0, 0);
    vec(0, ON,  A2,   2, 1, 0, 0);
    vec(0, ON,  A2,   2, 1, 0, 0);
    vec(0, ON,  A2,   3, 1, 0, 0);
    vec(0, ON,  A2,   3, 1, 0, 0);
    vec(0, ON,  A3,   3, 0, 1, 0);
    // Active ignores acks
    vec(0, ON,  A0,   3, 0, 1, 0);
    // Power-down: one stage per cycle, descending
    vec(0, OFF, A0,   2, 1, 0, 0);
    vec(0, OFF, A0,   1, 1, 0, 0);
    vec(0, OFF, A0,   0, 0, 0, 0);
    vec(0, OFF, A0,   0, 0, 0, 0);
    // Abort mid-gap with idx=1
    vec(0, ON,  A0,   1, 1, 0, 0);
    vec(0, ON,  A0,   1, 1, 0, 0);
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   2, 1, 0, 0);
    vec(0, ON,  A1,   2, 1, 0, 0);
    vec(0, ON,  A2,   2, 1, 0, 0);
    vec(0, OFF, A2,   1, 1, 0, 0);
    vec(0, ON,  A2,   0, 0, 0, 0);   // On during teardown ignored
    vec(0, OFF, A0,   0, 0, 0, 0);
    // Invalid request during WaitAck -> sticky error
    vec(0, ON,  A0,   1, 1, 0, 0);
    vec(0, 4'b0000, A0, 0, 0, 0, 1);
    vec(0, ON,  A0,   0, 0, 0, 1);
    vec(0, ON,  A3,   0, 0, 0, 1);
    vec(1, ON,  A0,   0, 0, 0, 0);
    // Bad ack encoding: no progress
    vec(0, ON,  A0,   1, 1, 0, 0);
    for (int i = 0; i < 10; i++) vec(0, ON, ABAD, 1, 1, 0, 0);
    // Reset mid-ramp while stage 1 On
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   1, 1, 0, 0);
    vec(0, ON,  A1,   2, 1, 0, 0);
    vec(1, ON,  A1,   0, 0, 0, 0);
    vec(0, OFF, A0,   0, 0, 0, 0);
    // Invalid request in Idle, then clear with reset
    vec(0, 4'hF, A0,  0, 0, 0, 1);
    vec(1, OFF, A0,   0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
